// File: rtl/core_pkg.sv
// Shared RV32I core definitions: instruction constants,
// data width and the fetch-stage state encoding.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST    = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target mux for the fetch stage: sequential, PC-relative
// and register-indirect targets plus misaligned-redirect detection.
module next_pc_sel
  import core_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm32,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] target,
  output logic            redirect,
  output logic            misaligned
);

  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] ind_tgt;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    rel_tgt  = pc + imm32;
    ind_tgt  = (rs1_data + imm32) & ~32'h1;
    redirect = branch_taken | jal | jalr;

    // jalr wins when decode raises more than one redirect
    if (jalr) begin
      target = ind_tgt;
    end else if (branch_taken | jal) begin
      target = rel_tgt;
    end else begin
      target = pc_plus4;
    end

    misaligned = redirect & (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC register, boot/run/halt control,
// synchronous BRAM addressing and retired-instruction count.
module instruction_fetch
  import core_pkg::*;
#(
  parameter int              IMEM_AW  = 14,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic               jal,
  input  logic               jalr,
  input  logic [XLEN-1:0]    imm32,
  input  logic [XLEN-1:0]    rs1_data,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    inst,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  output logic               inst_valid,
  output logic               halted,
  output logic               fault,
  output logic [XLEN-1:0]    retired
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            misaligned;
  logic            unused_pc_bits;

  next_pc_sel u_next_pc_sel (
    .pc           (pc_q),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .imm32        (imm32),
    .rs1_data     (rs1_data),
    .pc_plus4     (pc_plus4),
    .target       (target),
    .redirect     (redirect),
    .misaligned   (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    fault_d    = fault_q;
    next_pc    = pc_q;
    inst       = NOP_INST;
    inst_valid = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        next_pc = RESET_PC;
      end
      RUN: begin
        inst       = imem_rdata;
        inst_valid = 1'b1;
        if (!stall) begin
          if (imem_rdata == EBREAK_INST) begin
            state_d   = HALT;
            retired_d = retired_q + 32'd1;
          end else if (misaligned) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            next_pc   = target;
            pc_d      = target;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      HALT: begin
        next_pc = pc_q;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // BRAM is addressed with the next PC so its data lines up with pc_q
  assign imem_addr = next_pc[IMEM_AW+1:2];
  assign unused_pc_bits = ^{redirect, next_pc[XLEN-1:IMEM_AW+2], next_pc[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  assign pc      = pc_q;
  assign halted  = (state_q == HALT);
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch with a
// behavioural fetch model and directed boot/branch/halt/wrap cases.
module tb_instruction_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch_taken, jal, jalr;
  logic [31:0] imm32, rs1_data;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata, inst, pc, pc_plus4, retired;
  logic        inst_valid, halted, fault;

  logic        rst2;
  logic [3:0]  imem_addr2;
  logic [31:0] imem_rdata2, inst2, pc2, pc_plus4_2, retired2;
  logic        inst_valid2, halted2, fault2;

  logic [31:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_run, m_halt, m_fault;
  logic [31:0] m_pc, m_ret;
  int          halt_cnt;

  instruction_fetch #(.IMEM_AW(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .jal(jal), .jalr(jalr),
    .imm32(imm32), .rs1_data(rs1_data),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .pc(pc), .pc_plus4(pc_plus4),
    .inst_valid(inst_valid), .halted(halted), .fault(fault),
    .retired(retired)
  );

  instruction_fetch #(.IMEM_AW(4), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .stall(1'b0),
    .branch_taken(1'b0), .jal(1'b0), .jalr(1'b0),
    .imm32(32'h0), .rs1_data(32'h0),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .inst(inst2), .pc(pc2), .pc_plus4(pc_plus4_2),
    .inst_valid(inst_valid2), .halted(halted2), .fault(fault2),
    .retired(retired2)
  );

  always @(posedge clk) imem_rdata  <= mem[imem_addr];
  always @(posedge clk) imem_rdata2 <= {28'h0, imem_addr2};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[int'((a >> 2) & 32'hFF)];
  endfunction

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_fault = 0;
    m_pc = 32'h0; m_ret = 32'h0;
  endtask

  // Inputs are already driven; check outputs, predict, advance one clock.
  task automatic cycle();
    logic [31:0] w, tgt, npc, nret, apc;
    bit          nrun, nhalt, nfault;
    #1;
    w = word_at(m_pc);
    chk("inst",       inst,             m_run ? w : NOP);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_run});
    chk("pc",         pc,               m_pc);
    chk("pc_plus4",   pc_plus4,         m_pc + 32'd4);
    chk("halted",     {31'b0, halted},  {31'b0, m_halt});
    chk("fault",      {31'b0, fault},   {31'b0, m_fault});
    chk("retired",    retired,          m_ret);
    nrun = m_run; nhalt = m_halt; nfault = m_fault;
    npc = m_pc; nret = m_ret; apc = m_pc;
    if (!m_run && !m_halt) begin
      nrun = 1;
      apc  = 32'h0;
    end else if (m_run) begin
      if (!stall) begin
        if (w == EBREAK) begin
          nrun = 0; nhalt = 1; nret = m_ret + 1;
        end else begin
          if (jalr)                    tgt = (rs1_data + imm32) & ~32'h1;
          else if (branch_taken || jal) tgt = m_pc + imm32;
          else                          tgt = m_pc + 32'd4;
          if ((branch_taken || jal || jalr) && (tgt % 4 != 0)) begin
            nrun = 0; nhalt = 1; nfault = 1;
          end else begin
            npc = tgt; nret = m_ret + 1;
          end
        end
      end
      apc = npc;
    end
    chk("imem_addr", {24'b0, imem_addr}, (apc >> 2) & 32'hFF);
    if (!rst) begin
      nrun = 0; nhalt = 0; nfault = 0; npc = 32'h0; nret = 32'h0;
    end
    @(posedge clk);
    m_run = nrun; m_halt = nhalt; m_fault = nfault;
    m_pc = npc; m_ret = nret;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; jal = 0; jalr = 0;
    imm32 = 32'h0; rs1_data = 32'h0;
  endtask

  initial begin
    rst = 0; rst2 = 0;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[0] = 32'h0050_0093;
    mem[1] = EBREAK;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_valid",   {31'b0, inst_valid}, 32'h0);
    chk("rst_inst",    inst,    NOP);
    chk("rst_retired", retired, 32'h0);

    // boot then ebreak at pc=4
    rst = 1;
    cycle();
    chk("boot_inst", inst, 32'h0050_0093);
    chk("boot_pc",   pc,   32'h0);
    cycle();
    chk("ebreak_pc", pc, 32'h4);
    cycle();
    chk("ebreak_halted",  {31'b0, halted}, 32'h1);
    chk("ebreak_retired", retired, 32'h2);

    // sequential with a 2-cycle stall at pc=8
    rst = 0;
    mem[1] = NOP;
    cycle();
    rst = 1;
    cycle();
    cycle();
    cycle();
    chk("pre_stall_pc", pc, 32'h8);
    stall = 1;
    cycle();
    cycle();
    stall = 0;
    chk("stall_pc", pc, 32'h8);
    cycle();
    chk("resume_pc",      pc,      32'hC);
    chk("resume_retired", retired, 32'h3);
    cycle();
    chk("seq_pc", pc, 32'h10);

    // branch back, jal forward, jalr with lsb clear, then misaligned jalr
    branch_taken = 1; imm32 = 32'hFFFF_FFF8;
    cycle();
    branch_taken = 0;
    chk("branch_pc",    pc, 32'h8);
    chk("branch_valid", {31'b0, inst_valid}, 32'h1);
    jal = 1; imm32 = 32'h100;
    cycle();
    jal = 0;
    chk("jal_pc", pc, 32'h108);
    jalr = 1; rs1_data = 32'h201; imm32 = 32'h0;
    cycle();
    chk("jalr_pc", pc, 32'h200);
    rs1_data = 32'h205; imm32 = 32'hFFFF_FFFF;
    cycle();
    chk("jalr_neg_pc", pc, 32'h204);
    rs1_data = 32'h203; imm32 = 32'h0;
    cycle();
    jalr = 0;
    chk("fault_flag",    {31'b0, fault},  32'h1);
    chk("fault_halted",  {31'b0, halted}, 32'h1);
    chk("fault_pc",      pc,      32'h204);
    chk("fault_retired", retired, 32'h8);
    stall = 1; jal = 1; imm32 = 32'h40;
    cycle();
    stall = 0;
    cycle();
    idle_inputs();
    chk("halt_hold_pc", pc, 32'h204);

    // reset out of HALT
    rst = 0;
    cycle();
    rst = 1;
    chk("rh_fault",   {31'b0, fault},  32'h0);
    chk("rh_halted",  {31'b0, halted}, 32'h0);
    chk("rh_retired", retired, 32'h0);
    chk("rh_pc",      pc,      32'h0);

    // randomized run over a random program
    rst = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 29) == 0) mem[i] = EBREAK;
      else if (mem[i] == EBREAK) mem[i] = mem[i] ^ 32'h1;
    end
    cycle();
    halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle_inputs();
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
      rst = !($urandom_range(0, 49) == 0 || halt_cnt > 4);
      stall = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 7);
      imm32 = (32'($urandom_range(0, 127)) - 32'd64) << 2;
      if ($urandom_range(0, 19) == 0) imm32 = imm32 + 32'd2;
      rs1_data = $urandom;
      if ($urandom_range(0, 3) != 0) rs1_data[1:0] = 2'($urandom_range(0, 1));
      branch_taken = (r == 0);
      jal          = (r == 1);
      jalr         = (r == 2);
      cycle();
    end
    idle_inputs();
    rst = 1;

    // wrap and alias with RESET_PC=0xFFFF_FFFC, 16-word memory
    rst2 = 0;
    @(posedge clk);
    @(negedge clk);
    rst2 = 1;
    chk("wrap_boot_addr",  {28'b0, imem_addr2}, 32'hF);
    chk("wrap_boot_valid", {31'b0, inst_valid2}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_pc0",   pc2, 32'hFFFF_FFFC);
    chk("wrap_addr0", {28'b0, imem_addr2}, 32'h0);
    chk("wrap_inst0", inst2, 32'hF);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_pc1",   pc2, 32'h0);
    chk("wrap_addr1", {28'b0, imem_addr2}, 32'h1);
    chk("wrap_ret",   retired2, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
